// File: rtl/duck_motion_ctrl.sv
// Duck flight controller: spawns a duck on each hunt, bounces it around the sky,
// drops it when shot. Define DUCK_ESCAPE_EN to make an unshot duck fly away.

module duck_motion_ctrl #(
    parameter int unsigned H_RES        = 1024,
    parameter int unsigned SKY_BOTTOM   = 560,
    parameter int unsigned DUCK_WIDTH   = 96,
    parameter int unsigned DUCK_HEIGHT  = 60,
    parameter int unsigned TICK_DIV     = 650_000,
    parameter int unsigned FLY_STEP     = 4,
    parameter int unsigned FALL_STEP    = 6,
    parameter int unsigned HIT_TICKS    = 50,
    parameter int unsigned ESCAPE_TICKS = 800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_enable,
    input  logic        hunt_start,
    input  logic        duck_killed,
    output logic [11:0] duck_xpos,
    output logic [11:0] duck_ypos,
    output logic        duck_dir_left,
    output logic        duck_visible,
    output logic        duck_down,
    output logic        duck_escaped
);

    localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned HitW  = (HIT_TICKS > 1) ? $clog2(HIT_TICKS) : 1;

    localparam logic [11:0] XMax       = 12'(H_RES - DUCK_WIDTH);
    localparam logic [11:0] XBounce    = 12'(H_RES - DUCK_WIDTH - FLY_STEP);
    localparam logic [11:0] YSpawn     = 12'(SKY_BOTTOM - DUCK_HEIGHT);
    localparam logic [11:0] YBotBounce = 12'(SKY_BOTTOM - DUCK_HEIGHT - FLY_STEP);
    localparam logic [11:0] SkyBot     = 12'(SKY_BOTTOM);
    localparam logic [11:0] FallEnd    = 12'(SKY_BOTTOM - FALL_STEP);
    localparam logic [11:0] FlyStep    = 12'(FLY_STEP);
    localparam logic [11:0] FallStep   = 12'(FALL_STEP);
    localparam logic [11:0] DuckW      = 12'(DUCK_WIDTH);

    if (TICK_DIV == 0 || HIT_TICKS == 0 || ESCAPE_TICKS == 0 || FLY_STEP == 0) begin : g_param_check
        $error("duck_motion_ctrl: tick counts and step sizes must be non-zero");
    end

`ifdef DUCK_ESCAPE_EN
    localparam int unsigned EscW = (ESCAPE_TICKS > 1) ? $clog2(ESCAPE_TICKS) : 1;
    typedef enum logic [2:0] {StHidden, StFlying, StHit, StFalling, StEscaping} state_e;
    logic [EscW-1:0] esc_cnt_q, esc_cnt_d;
    logic            escaped_q, escaped_d;
`else
    typedef enum logic [2:0] {StHidden, StFlying, StHit, StFalling} state_e;
`endif

    state_e            state_q, state_d;
    logic              hunt_cur_q, hunt_prev_q, kill_cur_q, kill_prev_q;
    logic [TickW-1:0]  tick_cnt_q, tick_cnt_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [11:0]       x_q, x_d, y_q, y_d, spawn_raw, spawn_x;
    logic              dir_left_q, dir_left_d, dir_up_q, dir_up_d;
    logic [HitW-1:0]   hit_cnt_q, hit_cnt_d;
    logic              visible_q, visible_d, down_q, down_d;
    logic              hunt_edge, kill_edge, tick, fly_move;

    assign hunt_edge  = hunt_cur_q & ~hunt_prev_q;
    assign kill_edge  = kill_cur_q & ~kill_prev_q;
    assign tick       = (tick_cnt_q == TickW'(TICK_DIV - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);
    assign lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    // Fold spawns past the right edge back so the sprite always fits.
    assign spawn_raw  = {2'b00, lfsr_q[9:0]};
    assign spawn_x    = (spawn_raw > XMax) ? spawn_raw - DuckW : spawn_raw;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        dir_left_d = dir_left_q;
        dir_up_d   = dir_up_q;
        hit_cnt_d  = hit_cnt_q;
        down_d     = 1'b0;
        fly_move   = 1'b0;
`ifdef DUCK_ESCAPE_EN
        esc_cnt_d  = esc_cnt_q;
        escaped_d  = 1'b0;
`endif
        if (!game_enable) begin
            state_d = StHidden;
        end else begin
            unique case (state_q)
                StHidden: begin
                    if (hunt_edge) begin
                        state_d    = StFlying;
                        x_d        = spawn_x;
                        y_d        = YSpawn;
                        dir_left_d = lfsr_q[15];
                        dir_up_d   = 1'b1;
`ifdef DUCK_ESCAPE_EN
                        esc_cnt_d  = '0;
`endif
                    end
                end
                StFlying: begin
                    if (kill_edge) begin
                        state_d   = StHit;
                        hit_cnt_d = '0;
                    end else if (tick) begin
                        fly_move = hunt_cur_q;
`ifdef DUCK_ESCAPE_EN
                        if (esc_cnt_q == EscW'(ESCAPE_TICKS - 1)) begin
                            state_d  = StEscaping;
                            dir_up_d = 1'b1;
                            fly_move = 1'b0;
                        end else begin
                            esc_cnt_d = esc_cnt_q + EscW'(1);
                        end
`endif
                    end
                end
                StHit: begin
                    if (tick) begin
                        if (hit_cnt_q == HitW'(HIT_TICKS - 1)) state_d = StFalling;
                        else hit_cnt_d = hit_cnt_q + HitW'(1);
                    end
                end
                StFalling: begin
                    if (tick) begin
                        if (y_q >= FallEnd) begin
                            y_d     = SkyBot;
                            down_d  = 1'b1;
                            state_d = StHidden;
                        end else begin
                            y_d = y_q + FallStep;
                        end
                    end
                end
`ifdef DUCK_ESCAPE_EN
                StEscaping: begin
                    if (tick) begin
                        if (y_q <= FlyStep) begin
                            y_d       = '0;
                            escaped_d = 1'b1;
                            state_d   = StHidden;
                        end else begin
                            y_d = y_q - FlyStep;
                        end
                    end
                end
`endif
                default: state_d = StHidden;
            endcase
        end

        // Bounce tests compare before stepping so nothing wraps.
        if (fly_move) begin
            if (dir_left_q) begin
                if (x_q <= FlyStep) begin
                    x_d        = '0;
                    dir_left_d = 1'b0;
                end else begin
                    x_d = x_q - FlyStep;
                end
            end else if (x_q >= XBounce) begin
                x_d        = XMax;
                dir_left_d = 1'b1;
            end else begin
                x_d = x_q + FlyStep;
            end
            if (dir_up_q) begin
                if (y_q <= FlyStep) begin
                    y_d      = '0;
                    dir_up_d = 1'b0;
                end else begin
                    y_d = y_q - FlyStep;
                end
            end else if (y_q >= YBotBounce) begin
                y_d      = YSpawn;
                dir_up_d = 1'b1;
            end else begin
                y_d = y_q + FlyStep;
            end
        end

        visible_d = (state_d != StHidden);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StHidden;
            hunt_cur_q  <= 1'b0;
            hunt_prev_q <= 1'b0;
            kill_cur_q  <= 1'b0;
            kill_prev_q <= 1'b0;
            tick_cnt_q  <= '0;
            lfsr_q      <= 16'hACE1;
            x_q         <= '0;
            y_q         <= SkyBot;
            dir_left_q  <= 1'b0;
            dir_up_q    <= 1'b0;
            hit_cnt_q   <= '0;
            visible_q   <= 1'b0;
            down_q      <= 1'b0;
`ifdef DUCK_ESCAPE_EN
            esc_cnt_q   <= '0;
            escaped_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hunt_cur_q  <= hunt_start;
            hunt_prev_q <= hunt_cur_q;
            kill_cur_q  <= duck_killed;
            kill_prev_q <= kill_cur_q;
            tick_cnt_q  <= tick_cnt_d;
            lfsr_q      <= lfsr_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dir_left_q  <= dir_left_d;
            dir_up_q    <= dir_up_d;
            hit_cnt_q   <= hit_cnt_d;
            visible_q   <= visible_d;
            down_q      <= down_d;
`ifdef DUCK_ESCAPE_EN
            esc_cnt_q   <= esc_cnt_d;
            escaped_q   <= escaped_d;
`endif
        end
    end

    assign duck_xpos     = x_q;
    assign duck_ypos     = y_q;
    assign duck_dir_left = dir_left_q;
    assign duck_visible  = visible_q;
    assign duck_down     = down_q;
`ifdef DUCK_ESCAPE_EN
    assign duck_escaped  = escaped_q;
`else
    assign duck_escaped  = 1'b0;
`endif

endmodule

// File: tb/tb_duck_motion_ctrl.sv
// Bench for duck_motion_ctrl: directed vector table, corner sequences and a random run,
// all checked every clock against a behavioural flight model.

module tb_duck_motion_ctrl;

    localparam int TD   = 4;
    localparam int HT   = 3;
    localparam int ET   = 10;
    localparam int XMAX = 928;
    localparam int YSP  = 500;
    localparam int SKY  = 560;

    localparam int MHid = 0, MFly = 1, MHit = 2, MFall = 3, MEsc = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        game_enable = 1'b0;
    logic        hunt_start = 1'b0;
    logic        duck_killed = 1'b0;
    logic [11:0] duck_xpos, duck_ypos;
    logic        duck_dir_left, duck_visible, duck_down, duck_escaped;

    always #5 clk = ~clk;

    duck_motion_ctrl #(
        .TICK_DIV     (TD),
        .HIT_TICKS    (HT),
        .ESCAPE_TICKS (ET),
        .FLY_STEP     (4),
        .FALL_STEP    (6)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .game_enable   (game_enable),
        .hunt_start    (hunt_start),
        .duck_killed   (duck_killed),
        .duck_xpos     (duck_xpos),
        .duck_ypos     (duck_ypos),
        .duck_dir_left (duck_dir_left),
        .duck_visible  (duck_visible),
        .duck_down     (duck_down),
        .duck_escaped  (duck_escaped)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Behavioural model state
    int          m_mode, m_x, m_y, m_dl, m_du, m_hitc, m_escc, m_down, m_escp, m_n;
    bit          h1, h2, k1, k2;
    logic [15:0] m_lfsr;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model across one clock edge using the inputs currently applied.
    task automatic model_clock();
        bit he, ke, tick;
        int nx, ny;
        if (rst) begin
            m_mode = MHid; m_x = 0; m_y = SKY; m_dl = 0; m_du = 0;
            m_hitc = 0; m_escc = 0; m_down = 0; m_escp = 0; m_n = 0;
            m_lfsr = 16'hACE1; h1 = 0; h2 = 0; k1 = 0; k2 = 0;
            return;
        end
        he = h1 && !h2;
        ke = k1 && !k2;
        tick = (m_n % TD) == TD - 1;
        m_down = 0;
        m_escp = 0;
        if (!game_enable) begin
            m_mode = MHid;
        end else begin
            case (m_mode)
                MHid: if (he) begin
                    m_mode = MFly;
                    m_x = int'(m_lfsr[9:0]);
                    if (m_x > XMAX) m_x = m_x - 96;
                    m_y = YSP; m_dl = int'(m_lfsr[15]); m_du = 1; m_escc = 0;
                end
                MFly: if (ke) begin
                    m_mode = MHit; m_hitc = 0;
                end else if (tick) begin
                    bit move;
                    move = h1;
`ifdef DUCK_ESCAPE_EN
                    m_escc++;
                    if (m_escc == ET) begin m_mode = MEsc; m_du = 1; move = 0; end
`endif
                    if (move) begin
                        nx = m_dl != 0 ? m_x - 4 : m_x + 4;
                        if (nx >= XMAX) begin nx = XMAX; m_dl = 1; end
                        else if (nx <= 0) begin nx = 0; m_dl = 0; end
                        ny = m_du != 0 ? m_y - 4 : m_y + 4;
                        if (ny <= 0) begin ny = 0; m_du = 0; end
                        else if (ny >= YSP) begin ny = YSP; m_du = 1; end
                        m_x = nx; m_y = ny;
                    end
                end
                MHit: if (tick) begin
                    m_hitc++;
                    if (m_hitc == HT) m_mode = MFall;
                end
                MFall: if (tick) begin
                    if (m_y + 6 >= SKY) begin m_y = SKY; m_down = 1; m_mode = MHid; end
                    else m_y = m_y + 6;
                end
                MEsc: if (tick) begin
                    if (m_y <= 4) begin m_y = 0; m_escp = 1; m_mode = MHid; end
                    else m_y = m_y - 4;
                end
                default: m_mode = MHid;
            endcase
        end
        m_n++;
        m_lfsr = lfsr_next(m_lfsr);
        h2 = h1; h1 = hunt_start;
        k2 = k1; k1 = duck_killed;
    endtask

    task automatic step();
        model_clock();
        @(posedge clk);
        #1;
        chk("model_x", int'(duck_xpos), m_x);
        chk("model_y", int'(duck_ypos), m_y);
        chk("model_dir_left", int'(duck_dir_left), m_dl);
        chk("model_visible", int'(duck_visible), (m_mode != MHid) ? 1 : 0);
        chk("model_down", int'(duck_down), m_down);
        chk("model_escaped", int'(duck_escaped), m_escp);
    endtask

    task automatic do_reset();
        rst = 1'b1; hunt_start = 1'b0; duck_killed = 1'b0; game_enable = 1'b1;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic spawn();
        hunt_start = 1'b1;
        step(); step();
        chk("spawn_visible", int'(duck_visible), 1);
        chk("spawn_y", int'(duck_ypos), YSP);
    endtask

    typedef struct {
        bit rst, en, hunt, kill;
        int cycles;
        int vis, y, x, down;   // x < 0: not checked here
    } vec_t;

    vec_t tbl [10];

    initial begin
        int bounces, pulses, downs, yhold;
        logic pdl;

        // Ticks fall on post-reset clocks 3,7,11,...; the kill edge lands on tick 27.
        tbl = '{
            '{1'b1, 1'b1, 1'b0, 1'b0,  2, 0, 560,  0, 0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 20, 0, 560,  0, 0},
            '{1'b0, 1'b1, 1'b1, 1'b0,  2, 1, 500, -1, 0},
            '{1'b0, 1'b1, 1'b1, 1'b0,  2, 1, 496, -1, 0},
            '{1'b0, 1'b1, 1'b1, 1'b0,  2, 1, 496, -1, 0},
            '{1'b0, 1'b1, 1'b1, 1'b1,  2, 1, 496, -1, 0},
            '{1'b0, 1'b1, 1'b1, 1'b1, 12, 1, 496, -1, 0},
            '{1'b0, 1'b1, 1'b1, 1'b1, 40, 1, 556, -1, 0},
            '{1'b0, 1'b1, 1'b1, 1'b1,  4, 0, 560, -1, 1},
            '{1'b0, 1'b1, 1'b1, 1'b1,  1, 0, 560, -1, 0}
        };

        for (int r = 0; r < 10; r++) begin
            rst = tbl[r].rst; game_enable = tbl[r].en;
            hunt_start = tbl[r].hunt; duck_killed = tbl[r].kill;
            repeat (tbl[r].cycles) step();
            chk($sformatf("vec%0d_visible", r), int'(duck_visible), tbl[r].vis);
            chk($sformatf("vec%0d_y", r), int'(duck_ypos), tbl[r].y);
            chk($sformatf("vec%0d_down", r), int'(duck_down), tbl[r].down);
            if (tbl[r].x >= 0) chk($sformatf("vec%0d_x", r), int'(duck_xpos), tbl[r].x);
        end

`ifndef DUCK_ESCAPE_EN
        // Horizontal bounces must clamp exactly at the playfield edges.
        do_reset();
        spawn();
        bounces = 0;
        for (int i = 0; i < 5000 && bounces < 2; i++) begin
            pdl = duck_dir_left;
            step();
            if (duck_dir_left != pdl) begin
                bounces++;
                chk("bounce_x", int'(duck_xpos), (duck_dir_left == 1'b1) ? XMAX : 0);
            end
        end
        chk("bounce_count", bounces, 2);
`endif

        // Escape timeout (or its absence in the default build).
        do_reset();
        spawn();
        pulses = 0;
        for (int i = 0; i < 800; i++) begin
            step();
            if (duck_escaped) begin
                pulses++;
                chk("escape_y", int'(duck_ypos), 0);
            end
        end
`ifdef DUCK_ESCAPE_EN
        chk("escape_pulses", pulses, 1);
        chk("escape_hidden", int'(duck_visible), 0);
`else
        chk("noescape_pulses", pulses, 0);
        chk("noescape_visible", int'(duck_visible), 1);
`endif

        // game_enable dropped while falling.
        do_reset();
        spawn();
        repeat (6) step();
        duck_killed = 1'b1;
        for (int i = 0; i < 200 && m_mode != MFall; i++) step();
        chk("reach_falling", (m_mode == MFall) ? 1 : 0, 1);
        repeat (5) step();
        yhold = int'(duck_ypos);
        game_enable = 1'b0;
        step();
        chk("disable_visible", int'(duck_visible), 0);
        chk("disable_y_hold", int'(duck_ypos), yhold);
        downs = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (duck_down) downs++;
        end
        chk("disable_no_down", downs, 0);
        game_enable = 1'b1;
        duck_killed = 1'b0;

        // Reset in the middle of flight.
        do_reset();
        spawn();
        repeat (30) step();
        rst = 1'b1;
        step();
        chk("rst_x", int'(duck_xpos), 0);
        chk("rst_y", int'(duck_ypos), SKY);
        chk("rst_visible", int'(duck_visible), 0);
        chk("rst_dir_left", int'(duck_dir_left), 0);
        chk("rst_down", int'(duck_down), 0);
        chk("rst_escaped", int'(duck_escaped), 0);
        rst = 1'b0;
        hunt_start = 1'b0;

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) hunt_start = ~hunt_start;
            duck_killed = ($urandom_range(0, 29) == 0);
            game_enable = ($urandom_range(0, 299) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/duck_motion_ctrl.md
# duck_motion_ctrl

Duck flight controller, the counterpart of the game-logic block. It consumes `hunt_start` and `duck_killed` and produces the `duck_xpos`/`duck_ypos` that the game logic hit-tests and the duck sprite renderer draws. It spawns a duck on each new hunt, flies it with edge bounces, freezes and drops it on a kill, and optionally makes it fly away after a timeout.

## Interface
Parameters:
- `H_RES`, 1024: horizontal playfield width, px.
- `SKY_BOTTOM`, 560: lowest y of the flight area (grass line), px.
- `DUCK_WIDTH`, 96: sprite width, px.
- `DUCK_HEIGHT`, 60: sprite height, px.
- `TICK_DIV`, 650_000: clocks per motion tick (10 ms at 65 MHz).
- `FLY_STEP`, 4: px per tick per axis while flying or escaping.
- `FALL_STEP`, 6: px per tick while falling.
- `HIT_TICKS`, 50: ticks the duck stays frozen after a kill.
- `ESCAPE_TICKS`, 800: flying ticks before escape (used only with `DUCK_ESCAPE_EN`).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  posedge clock.
- `rst`  in  1  synchronous reset, active high.
- `game_enable`  in  1  low forces HIDDEN.
- `hunt_start`  in  1  level; a rising edge spawns a duck.
- `duck_killed`  in  1  level or pulse; a rising edge registers a hit.
- `duck_xpos`  out  12  sprite left x.
- `duck_ypos`  out  12  sprite top y.
- `duck_dir_left`  out  1  1 = moving left (sprite mirror).
- `duck_visible`  out  1  1 outside HIDDEN.
- `duck_down`  out  1  1-cycle pulse when the fall reaches `SKY_BOTTOM`.
- `duck_escaped`  out  1  1-cycle pulse when the escape reaches y = 0.

## Operation
- Edge detection: registered copies of `hunt_start` and `duck_killed`; edge = current & ~prev.
- Tick prescaler: counts 0..TICK_DIV-1 and pulses `tick` on wrap. It is reset only by `rst` and runs freely in every state.
- LFSR: 16-bit, taps 16,14,13,11, seed 16'hACE1, advances every clock, never all-zero.
- States: HIDDEN, FLYING, HIT, FALLING, ESCAPING.
- HIDDEN → FLYING on a hunt_start edge with game_enable = 1. Spawn values:
  - x = {2'b0, lfsr[9:0]}; if x > H_RES-DUCK_WIDTH, x = x - DUCK_WIDTH.
  - y = SKY_BOTTOM-DUCK_HEIGHT.
  - dir_left = lfsr[15]; dir_up = 1.
  - The escape counter is cleared.
- FLYING: each tick moves x by ±FLY_STEP and y by ±FLY_STEP, but only while hunt_start = 1; otherwise the duck holds.
  - Horizontal: moving right with x+FLY_STEP ≥ H_RES-DUCK_WIDTH clamps x to H_RES-DUCK_WIDTH and sets dir_left = 1. Moving left with x ≤ FLY_STEP clamps x to 0 and sets dir_left = 0.
  - Vertical: moving up with y ≤ FLY_STEP clamps y to 0 and sets dir_up = 0. Moving down with y+FLY_STEP ≥ SKY_BOTTOM-DUCK_HEIGHT clamps y to SKY_BOTTOM-DUCK_HEIGHT and sets dir_up = 1.
- FLYING → HIT on a duck_killed edge. Position is frozen and the hit counter is cleared.
- HIT → FALLING after HIT_TICKS ticks.
- FALLING: each tick y += FALL_STEP and x holds. When y+FALL_STEP ≥ SKY_BOTTOM, y is set to SKY_BOTTOM, `duck_down` pulses, and the state goes to HIDDEN.
- ESCAPING: each tick y -= FLY_STEP and x holds. When y ≤ FLY_STEP, y is set to 0, `duck_escaped` pulses, and the state goes to HIDDEN.
- Priority, highest first: rst, game_enable = 0 (→ HIDDEN), duck_killed edge, tick motion/bounce.
  - A kill edge and a tick in the same cycle: the kill wins and no move is applied.
  - duck_killed edges in HIDDEN, HIT, FALLING or ESCAPING are ignored.
  - hunt_start edges outside HIDDEN are ignored.
- All arithmetic is unsigned 12-bit. Every clamp comparison is done before the add/subtract, so no wrap-around occurs.

## Timing
- Reset values:
  - state = HIDDEN.
  - duck_xpos = 0, duck_ypos = SKY_BOTTOM.
  - duck_dir_left = 0, duck_visible = 0, duck_down = 0, duck_escaped = 0.
  - Prescaler, hit counter and escape counter = 0; LFSR = seed.
- All outputs are registered. A state or position change is visible one clock after the causing edge or tick.
- Spawn: duck_visible rises 2 clocks after the hunt_start rise (1 for edge detect, 1 for the output register).
- Motion rate: exactly one step per TICK_DIV clocks.
- In HIDDEN the outputs hold the last position and duck_visible = 0.

## Configuration
- `DUCK_ESCAPE_EN` defined:
  - FLYING counts ticks; at ESCAPE_TICKS with no kill it enters ESCAPING with dir_up forced to 1.
  - A kill edge in the same cycle as the timeout wins and the state goes to HIT.
- `DUCK_ESCAPE_EN` undefined:
  - No escape counter or ESCAPING state is compiled.
  - The duck flies indefinitely and duck_escaped is tied to 0.

## Test plan
All scenarios use TICK_DIV=4, HIT_TICKS=3, ESCAPE_TICKS=10, FLY_STEP=4, FALL_STEP=6.
- Reset, then idle 20 clocks → xpos=0, ypos=560, visible=0, no pulses.
- hunt_start 0→1 with seed 16'hACE1 → visible=1 two clocks later, ypos=500, xpos ≤ 928 and equal to the reference-model LFSR value.
- Force x = 926 moving right, one tick → xpos=928, dir_left=1; next tick → xpos=924.
- duck_killed rise coincident with a tick at y = 300 → no move. After 3 ticks, FALLING at +6 px/tick until ypos=560, one-cycle duck_down, visible=0.
- With DUCK_ESCAPE_EN and no kill → after 10 ticks ypos decreases by 4 px/tick to 0, one-cycle duck_escaped, then HIDDEN. Without the macro → still FLYING after 100 ticks.
- game_enable dropped mid-FALLING → HIDDEN next clock, visible=0, no duck_down. rst asserted mid-FLYING → all outputs at reset values next clock.
